stack_sequencer: RTL and testbench

//  Multi-cycle executor for the control unit's non-single-cycle codes (state 2'b10 CALL/RET, 2'b11 INT/RETI).

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/stack_sequencer_if.sv | 26 ++
 rtl/stack_sequencer_stack_pointer.sv | 53 +++++
 rtl/stack_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the stack sequencer.
// Holds the control-unit sequence codes and the encodings of the sequencer's
// FSM, sequence kind and stack-pointer operation.
package pipe_pkg;

    // Control-unit sequence codes
    localparam logic [1:0] ST_SINGLE  = 2'b00;
    localparam logic [1:0] ST_CALLRET = 2'b10;
    localparam logic [1:0] ST_INTRET  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_FL,
        S_POP_F,
        S_POP_A,
        S_POP_B,
        S_FIN
    } seq_state_e;

    // Which sequence is running; selects the branch at PUSH_LO and whether
    // POP_A also restores flags.
    typedef enum logic [1:0] {
        K_CALL,
        K_INT,
        K_RET,
        K_RETI
    } seq_kind_e;

    typedef enum logic [1:0] {
        SP_HOLD,
        SP_PUSH,
        SP_POP
    } sp_op_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// Data-memory port of the stack sequencer.
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_wr    : write strobe
//   mem_rd    : read strobe; mem_rdata is valid the cycle after
//   mem_rdata : read data
// master = sequencer side, slave = memory side.
interface stack_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_wr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_wr, mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wr, mem_rd,
        output mem_rdata
    );
endinterface

// File: rtl/stack_sequencer_stack_pointer.sv
// Stack pointer register for the stack sequencer.
//   clk, rst_n : clock, async active-low reset (sp returns to SP_INIT)
//   op         : hold / push (sp-1) / pop (sp+1)
//   sp         : current stack pointer
//   push_addr  : address a push writes (sp)
//   pop_addr   : address a pop reads (sp+1, modulo)
//   wrap       : high while the requested op crosses the stack boundary
module stack_pointer
    import pipe_pkg::*;
#(
    parameter int          ADDR_W  = 11,
    parameter int unsigned SP_INIT = 2047
) (
    input  logic              clk,
    input  logic              rst_n,
    input  sp_op_e            op,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] pop_addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(SP_INIT);

    logic [ADDR_W-1:0] sp_q, sp_d;

    assign sp        = sp_q;
    assign push_addr = sp_q;
    assign pop_addr  = sp_q + ADDR_W'(1);

    always_comb begin
        sp_d = sp_q;
        wrap = 1'b0;
        case (op)
            SP_PUSH: begin
                sp_d = sp_q - ADDR_W'(1);
                wrap = (sp_q == '0);
            end
            SP_POP: begin
                sp_d = pop_addr;
                // Popping from the empty-stack position underflows.
                wrap = (sp_q == SP_TOP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= SP_TOP;
        else        sp_q <= sp_d;
    end

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle executor for CALL/RET and INT/RETI.
// Owns the stack pointer, sequences return-address and flag pushes/pops to
// data memory, stalls the pipeline while busy and issues the PC redirect.
//   clk, rst_n       : clock, async active-low reset (aborts any sequence)
//   start, state     : CU codes valid / sequence code
//   push_pc, pop_pc  : CU CALL / RET-RETI selects
//   interrupt        : level interrupt request
//   ret_pc, call_target, flags_in : operands captured on accept
//   mem              : data-memory port (master)
//   stall            : hold fetch/decode
//   pc_load, pc_out  : PC redirect strobe and value
//   flags_load, flags_out : flag restore strobe and value
//   sp               : stack pointer
//   stack_err        : pulse when a push/pop wraps the stack
module stack_sequencer
    import pipe_pkg::*;
#(
    parameter int          ADDR_W  = 11,
    parameter int unsigned SP_INIT = 2047,
    parameter logic [31:0] INT_VEC = 32'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        state,
    input  logic              push_pc,
    input  logic              pop_pc,
    input  logic              interrupt,
    input  logic [31:0]       ret_pc,
    input  logic [31:0]       call_target,
    input  logic [2:0]        flags_in,
    stack_sequencer_if.master mem,
    output logic              stall,
    output logic              pc_load,
    output logic [31:0]       pc_out,
    output logic              flags_load,
    output logic [2:0]        flags_out,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    seq_state_e  fsm_q, fsm_d;
    seq_kind_e   kind_q, kind_d, go_kind;
    logic        int_pend_q, int_pend_d;
    logic [31:0] ret_pc_q, ret_pc_d;
    logic [31:0] target_q, target_d;
    logic [2:0]  flags_q, flags_d;
    logic [15:0] lo_q, lo_d;
    logic        go;

    sp_op_e            sp_op;
    logic [ADDR_W-1:0] push_addr, pop_addr;
    logic              sp_wrap;

    logic [ADDR_W-1:0] addr_c;
    logic [15:0]       wdata_c;
    logic              wr_c, rd_c;

    stack_pointer #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (sp_op),
        .sp        (sp),
        .push_addr (push_addr),
        .pop_addr  (pop_addr),
        .wrap      (sp_wrap)
    );

    always_comb begin
        fsm_d      = fsm_q;
        kind_d     = kind_q;
        int_pend_d = int_pend_q;
        ret_pc_d   = ret_pc_q;
        target_d   = target_q;
        flags_d    = flags_q;
        lo_d       = lo_q;
        go         = 1'b0;
        go_kind    = K_CALL;
        sp_op      = SP_HOLD;
        addr_c     = '0;
        wdata_c    = '0;
        wr_c       = 1'b0;
        rd_c       = 1'b0;
        pc_load    = 1'b0;
        pc_out     = '0;
        flags_load = 1'b0;
        flags_out  = '0;

        // Accept decode; interrupts take priority over the CU codes.
        if (fsm_q == S_IDLE) begin
            if (int_pend_q || interrupt) begin
                go      = 1'b1;
                go_kind = K_INT;
            end else if (start) begin
                case (state)
                    ST_CALLRET: begin
                        if (push_pc) begin
                            go      = 1'b1;
                            go_kind = K_CALL;
                        end else if (pop_pc) begin
                            go      = 1'b1;
                            go_kind = K_RET;
                        end
                    end
                    ST_INTRET: begin
                        if (pop_pc) begin
                            go      = 1'b1;
                            go_kind = K_RETI;
                        end
                    end
                    ST_SINGLE: ;
                    default:   ;
                endcase
            end
        end else if (interrupt) begin
            // Remember the request; it is taken once the sequence ends.
            int_pend_d = 1'b1;
        end

        if (go) begin
            kind_d   = go_kind;
            ret_pc_d = ret_pc;
            target_d = call_target;
            flags_d  = flags_in;
            if (go_kind == K_INT) int_pend_d = 1'b0;
            case (go_kind)
                K_CALL, K_INT: fsm_d = S_PUSH_HI;
                K_RET:         fsm_d = S_POP_A;
                default:       fsm_d = S_POP_F;
            endcase
        end

        case (fsm_q)
            S_PUSH_HI: begin
                wr_c    = 1'b1;
                addr_c  = push_addr;
                wdata_c = ret_pc_q[31:16];
                sp_op   = SP_PUSH;
                fsm_d   = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                wr_c    = 1'b1;
                addr_c  = push_addr;
                wdata_c = ret_pc_q[15:0];
                sp_op   = SP_PUSH;
                if (kind_q == K_CALL) begin
                    pc_load = 1'b1;
                    pc_out  = target_q;
                    fsm_d   = S_IDLE;
                end else begin
                    fsm_d   = S_PUSH_FL;
                end
            end
            S_PUSH_FL: begin
                wr_c    = 1'b1;
                addr_c  = push_addr;
                wdata_c = {13'b0, flags_q};
                sp_op   = SP_PUSH;
                pc_load = 1'b1;
                pc_out  = INT_VEC;
                fsm_d   = S_IDLE;
            end
            S_POP_F: begin
                rd_c   = 1'b1;
                addr_c = pop_addr;
                sp_op  = SP_POP;
                fsm_d  = S_POP_A;
            end
            S_POP_A: begin
                rd_c   = 1'b1;
                addr_c = pop_addr;
                sp_op  = SP_POP;
                // For RETI the flag word read in POP_F is on rdata now.
                if (kind_q == K_RETI) begin
                    flags_load = 1'b1;
                    flags_out  = mem.mem_rdata[2:0];
                end
                fsm_d  = S_POP_B;
            end
            S_POP_B: begin
                rd_c   = 1'b1;
                addr_c = pop_addr;
                sp_op  = SP_POP;
                lo_d   = mem.mem_rdata;
                fsm_d  = S_FIN;
            end
            S_FIN: begin
                pc_load = 1'b1;
                pc_out  = {mem.mem_rdata, lo_q};
                fsm_d   = S_IDLE;
            end
            default: ;
        endcase
    end

    assign stall         = (fsm_q != S_IDLE) || go;
    assign stack_err     = sp_wrap;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;
    assign mem.mem_wr    = wr_c;
    assign mem.mem_rd    = rd_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= S_IDLE;
            kind_q     <= K_CALL;
            int_pend_q <= 1'b0;
            ret_pc_q   <= '0;
            target_q   <= '0;
            flags_q    <= '0;
            lo_q       <= '0;
        end else begin
            fsm_q      <= fsm_d;
            kind_q     <= kind_d;
            int_pend_q <= int_pend_d;
            ret_pc_q   <= ret_pc_d;
            target_q   <= target_d;
            flags_q    <= flags_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer. The reference is a plain word
// stack (array + pointer); each operation's expected bus activity, redirect
// and flag values come from pushing/popping that model.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  state = 2'b00;
    logic        push_pc = 1'b0;
    logic        pop_pc = 1'b0;
    logic        interrupt = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [31:0] call_target = '0;
    logic [2:0]  flags_in = '0;
    logic        stall, pc_load, flags_load, stack_err;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;
    logic [10:0] sp;

    int checks = 0;
    int errors = 0;

    stack_sequencer_if #(.ADDR_W(11)) m ();

    stack_sequencer #(.ADDR_W(11), .SP_INIT(2047), .INT_VEC(32'h20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .state       (state),
        .push_pc     (push_pc),
        .pop_pc      (pop_pc),
        .interrupt   (interrupt),
        .ret_pc      (ret_pc),
        .call_target (call_target),
        .flags_in    (flags_in),
        .mem         (m),
        .stall       (stall),
        .pc_load     (pc_load),
        .pc_out      (pc_out),
        .flags_load  (flags_load),
        .flags_out   (flags_out),
        .sp          (sp),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, one-cycle read latency.
    logic [15:0] ram [0:2047] = '{default: 16'h0};
    logic [15:0] rdata_q = '0;
    always @(posedge clk) begin
        if (m.mem_wr) ram[m.mem_addr] <= m.mem_wdata;
        if (m.mem_rd) rdata_q <= ram[m.mem_addr];
    end
    assign m.mem_rdata = rdata_q;

    // Reference stack
    logic [15:0] ref_mem [0:2047] = '{default: 16'h0};
    int ref_sp = 2047;

    task automatic ref_push(input logic [15:0] v, output int addr, output logic err);
        addr = ref_sp;
        err = (ref_sp == 0);
        ref_mem[ref_sp] = v;
        ref_sp = (ref_sp - 1) & 2047;
    endtask

    task automatic ref_pop(output logic [15:0] v, output int addr, output logic err);
        err = (ref_sp == 2047);
        ref_sp = (ref_sp + 1) & 2047;
        addr = ref_sp;
        v = ref_mem[ref_sp];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // One busy cycle of a sequence.
    task automatic chk_cyc(input string tag, input logic wr, input logic rd, input int addr,
                           input logic [15:0] wd, input logic pl, input logic [31:0] pco,
                           input logic fl, input logic [2:0] flo, input logic err);
        chk({tag, ".stall"}, 32'(stall), 32'd1);
        chk({tag, ".wr"}, 32'(m.mem_wr), 32'(wr));
        chk({tag, ".rd"}, 32'(m.mem_rd), 32'(rd));
        if (wr || rd) chk({tag, ".addr"}, 32'(m.mem_addr), addr);
        if (wr) chk({tag, ".wdata"}, 32'(m.mem_wdata), 32'(wd));
        chk({tag, ".pc_load"}, 32'(pc_load), 32'(pl));
        if (pl) chk({tag, ".pc_out"}, pc_out, pco);
        chk({tag, ".flags_load"}, 32'(flags_load), 32'(fl));
        if (fl) chk({tag, ".flags_out"}, 32'(flags_out), 32'(flo));
        chk({tag, ".stack_err"}, 32'(stack_err), 32'(err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; push_pc = 1'b0; pop_pc = 1'b0; interrupt = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
        ref_sp = 2047;
        #1;
    endtask

    // CALL; start stays high through the busy cycles to show it is ignored.
    // irq_hi pulses interrupt during PUSH_HI, so the cycle after completion
    // is expected to accept an INT.
    task automatic do_call(input logic [31:0] rp, input logic [31:0] tgt, input bit irq_hi);
        int a0, a1;
        logic e0, e1;
        start = 1'b1; state = 2'b10; push_pc = 1'b1; pop_pc = 1'b0;
        ret_pc = rp; call_target = tgt;
        #1;
        chk("call.accept", 32'(stall), 32'd1);
        nxt();
        ret_pc = $urandom; call_target = $urandom; interrupt = irq_hi;
        #1;
        chk("call.hi.sp", 32'(sp), ref_sp);
        ref_push(rp[31:16], a0, e0);
        chk_cyc("call.hi", 1'b1, 1'b0, a0, rp[31:16], 1'b0, 32'h0, 1'b0, 3'b0, e0);
        nxt();
        interrupt = 1'b0;
        #1;
        chk("call.lo.sp", 32'(sp), ref_sp);
        ref_push(rp[15:0], a1, e1);
        chk_cyc("call.lo", 1'b1, 1'b0, a1, rp[15:0], 1'b1, tgt, 1'b0, 3'b0, e1);
        nxt();
        start = 1'b0; push_pc = 1'b0;
        #1;
        chk("call.done.stall", 32'(stall), 32'(irq_hi));
        chk("call.done.wr", 32'(m.mem_wr), 32'd0);
        chk("call.done.pc_load", 32'(pc_load), 32'd0);
        chk("call.done.sp", 32'(sp), ref_sp);
        chk("call.ram.hi", 32'(ram[a0]), 32'(rp[31:16]));
        chk("call.ram.lo", 32'(ram[a1]), 32'(rp[15:0]));
    endtask

    // INT entry; pend=1 means the request is already latched.
    task automatic do_int(input logic [2:0] fl, input logic [31:0] rp, input bit pend);
        int a0, a1, a2;
        logic e0, e1, e2;
        if (!pend) interrupt = 1'b1;
        ret_pc = rp; flags_in = fl;
        #1;
        chk("int.accept", 32'(stall), 32'd1);
        nxt();
        interrupt = 1'b0; ret_pc = $urandom; flags_in = 3'($urandom);
        #1;
        chk("int.hi.sp", 32'(sp), ref_sp);
        ref_push(rp[31:16], a0, e0);
        chk_cyc("int.hi", 1'b1, 1'b0, a0, rp[31:16], 1'b0, 32'h0, 1'b0, 3'b0, e0);
        nxt();
        #1;
        ref_push(rp[15:0], a1, e1);
        chk_cyc("int.lo", 1'b1, 1'b0, a1, rp[15:0], 1'b0, 32'h0, 1'b0, 3'b0, e1);
        nxt();
        #1;
        ref_push({13'b0, fl}, a2, e2);
        chk_cyc("int.fl", 1'b1, 1'b0, a2, {13'b0, fl}, 1'b1, 32'h20, 1'b0, 3'b0, e2);
        nxt();
        #1;
        chk("int.done.stall", 32'(stall), 32'd0);
        chk("int.done.sp", 32'(sp), ref_sp);
        chk("int.ram.hi", 32'(ram[a0]), 32'(rp[31:16]));
        chk("int.ram.lo", 32'(ram[a1]), 32'(rp[15:0]));
        chk("int.ram.fl", 32'(ram[a2]), 32'(fl));
    endtask

    // RET (reti=0) or RETI (reti=1).
    task automatic do_pop(input bit reti);
        logic [15:0] fw, lo, hi;
        int a;
        logic e;
        string p;
        fw = '0;
        p = reti ? "reti" : "ret";
        start = 1'b1; state = reti ? 2'b11 : 2'b10; push_pc = 1'b0; pop_pc = 1'b1;
        #1;
        chk({p, ".accept"}, 32'(stall), 32'd1);
        nxt();
        #1;
        if (reti) begin
            chk({p, ".f.sp"}, 32'(sp), ref_sp);
            ref_pop(fw, a, e);
            chk_cyc({p, ".f"}, 1'b0, 1'b1, a, 16'h0, 1'b0, 32'h0, 1'b0, 3'b0, e);
            nxt();
            #1;
        end
        chk({p, ".a.sp"}, 32'(sp), ref_sp);
        ref_pop(lo, a, e);
        chk_cyc({p, ".a"}, 1'b0, 1'b1, a, 16'h0, 1'b0, 32'h0, reti, fw[2:0], e);
        nxt();
        #1;
        chk({p, ".b.sp"}, 32'(sp), ref_sp);
        ref_pop(hi, a, e);
        chk_cyc({p, ".b"}, 1'b0, 1'b1, a, 16'h0, 1'b0, 32'h0, 1'b0, 3'b0, e);
        nxt();
        start = 1'b0; pop_pc = 1'b0;
        #1;
        chk_cyc({p, ".fin"}, 1'b0, 1'b0, 0, 16'h0, 1'b1, {hi, lo}, 1'b0, 3'b0, 1'b0);
        nxt();
        #1;
        chk({p, ".done.stall"}, 32'(stall), 32'd0);
        chk({p, ".done.pc_load"}, 32'(pc_load), 32'd0);
        chk({p, ".done.sp"}, 32'(sp), ref_sp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit frames[$];
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sp", 32'(sp), 32'd2047);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.wr", 32'(m.mem_wr), 32'd0);
        chk("rst.rd", 32'(m.mem_rd), 32'd0);
        chk("rst.addr", 32'(m.mem_addr), 32'd0);
        chk("rst.wdata", 32'(m.mem_wdata), 32'd0);
        chk("rst.pc_load", 32'(pc_load), 32'd0);
        chk("rst.pc_out", pc_out, 32'd0);
        chk("rst.flags_load", 32'(flags_load), 32'd0);
        chk("rst.flags_out", 32'(flags_out), 32'd0);
        chk("rst.stack_err", 32'(stack_err), 32'd0);
        rst_n = 1'b1;
        nxt();
        #1;
        chk("rel.sp", 32'(sp), 32'd2047);
        chk("rel.stall", 32'(stall), 32'd0);

        // Directed CALL/RET and INT/RETI
        do_call(32'h0001_0040, 32'h80, 1'b0);
        do_pop(1'b0);
        do_int(3'b101, 32'h0000_1234, 1'b0);
        do_pop(1'b1);
        chk("intret.sp", 32'(sp), 32'd2047);

        // Interrupt during CALL PUSH_HI: taken right after the CALL
        do_call(32'hCAFE_0100, 32'h400, 1'b1);
        do_int(3'b010, 32'h0000_0400, 1'b1);
        do_pop(1'b1);
        do_pop(1'b0);

        // Reset during RET POP_B
        do_call(32'hDEAD_BEEF, 32'h100, 1'b0);
        start = 1'b1; state = 2'b10; push_pc = 1'b0; pop_pc = 1'b1;
        nxt();
        #1;
        chk("abort.popa.rd", 32'(m.mem_rd), 32'd1);
        nxt();
        chk("abort.popb.rd", 32'(m.mem_rd), 32'd1);
        rst_n = 1'b0; start = 1'b0; pop_pc = 1'b0;
        #1;
        chk("abort.stall", 32'(stall), 32'd0);
        chk("abort.rd", 32'(m.mem_rd), 32'd0);
        chk("abort.pc_load", 32'(pc_load), 32'd0);
        chk("abort.sp", 32'(sp), 32'd2047);
        nxt();
        chk("abort.hold.pc_load", 32'(pc_load), 32'd0);
        rst_n = 1'b1;
        ref_sp = 2047;
        nxt();
        #1;
        chk("abort.after.pc_load", 32'(pc_load), 32'd0);
        chk("abort.after.stall", 32'(stall), 32'd0);
        chk("abort.after.sp", 32'(sp), 32'd2047);

        // Underflow: pop at 2047 wraps to 0; then a push at 0 wraps back
        do_pop(1'b0);
        do_call($urandom, $urandom, 1'b0);
        chk("wrap.sp", 32'(sp), 32'd2047);

        // Randomized nested CALL/INT with matching returns
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; state = 2'b00; push_pc = 1'($urandom); pop_pc = 1'($urandom);
                #1;
                chk("single.stall", 32'(stall), 32'd0);
                nxt();
                start = 1'b0; push_pc = 1'b0; pop_pc = 1'b0;
                #1;
                chk("single.sp", 32'(sp), ref_sp);
            end
            if (frames.size() == 0 || (frames.size() < 6 && $urandom_range(0, 1) == 1)) begin
                if ($urandom_range(0, 1) == 1) begin
                    do_call($urandom, $urandom, 1'b0);
                    frames.push_back(1'b0);
                end else begin
                    do_int(3'($urandom), $urandom, 1'b0);
                    frames.push_back(1'b1);
                end
            end else begin
                do_pop(frames.pop_back());
            end
        end
        while (frames.size() > 0) do_pop(frames.pop_back());
        chk("rand.final.sp", 32'(sp), 32'd2047);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
